// File: rtl/vm_pkg.sv
// vm_pkg: coin codes and coin encoder state encoding shared with the vending FSM
package vm_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_PEND} enc_state_t;
  function automatic logic [1:0] first_code(input logic half, input logic one);
    return half ? COIN_HALF : one ? COIN_ONE : COIN_NONE;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces one active-low key, pulses press on a debounced 1->0
// ports: clk, rst (sync, active-high), key_n (raw key, pressed = 0), press (one-cycle registered pulse)
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  logic [1:0] sync;
  logic [1:0] rdy;
  logic stable;
  logic armed;
  logic [CW-1:0] cnt;
  logic differ;
  logic done;
  assign differ = sync[1] != stable;
  assign done = differ && cnt == CW'(DEBOUNCE_CYC - 1);
  // armed stays low until the synchronized key has been seen released after reset,
  // so a key held through reset never produces a press
  always_ff @(posedge clk)
    if (rst) begin
      sync <= 2'b11;
      rdy <= 2'b00;
      stable <= 1'b1;
      armed <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      rdy <= {rdy[0], 1'b1};
      armed <= armed | (rdy[1] & sync[1]);
      cnt <= differ && !done ? cnt + 1'b1 : '0;
      stable <= done ? sync[1] : stable;
      press <= done && !sync[1] && armed;
    end
endmodule

// File: rtl/coin_encoder.sv
// coin_encoder: turns debounced coin key presses into one-cycle registered coin codes
// ports: clk, rst (sync, active-high), key_half/key_one (raw active-low keys),
//        inhibit (discard coins while high), coin (2-bit code), reject (one pulse per discarded press)
module coin_encoder import vm_pkg::*; #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_half,
  input  logic       key_one,
  input  logic       inhibit,
  output logic [1:0] coin,
  output logic       reject
);
  logic half_p;
  logic one_p;
  enc_state_t state;
  enc_state_t state_d;
  logic [1:0] pend;
  logic [1:0] head;
  logic [1:0] tail;
  logic [1:0] coin_d;
  logic reject_d;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_half (.clk(clk), .rst(rst), .key_n(key_half), .press(half_p));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_one (.clk(clk), .rst(rst), .key_n(key_one), .press(one_p));
  // head is served this cycle (older pending entry first, then half before one); tail waits in PEND
  always_comb begin
    head = state == ST_PEND ? pend : first_code(half_p, one_p);
    tail = state == ST_PEND ? first_code(half_p, one_p) : (half_p && one_p ? COIN_ONE : COIN_NONE);
    coin_d = inhibit ? COIN_NONE : head;
    reject_d = inhibit && head != COIN_NONE;
    state_d = tail != COIN_NONE ? ST_PEND : coin_d != COIN_NONE ? ST_EMIT : ST_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      pend <= COIN_NONE;
      coin <= COIN_NONE;
      reject <= 1'b0;
    end else begin
      state <= state_d;
      pend <= tail;
      coin <= coin_d;
      reject <= reject_d;
    end
endmodule

// File: tb/tb_coin_encoder.sv
// tb_coin_encoder: directed scenarios plus random presses against a cycle-level reference model
module tb_coin_encoder;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_half = 1'b1;
  logic key_one = 1'b1;
  logic inhibit = 1'b0;
  logic [1:0] coin;
  logic reject;
  int n_cmp = 0;
  int n_bad = 0;
  int h1[2], h2[2], stab[2], run[2];
  bit pev[2];
  int q[$];
  int exp_coin = 0, exp_rej = 0, press_sum = 0, rej_val = 0;

  coin_encoder #(.DEBOUNCE_CYC(DC)) dut (
    .clk(clk), .rst(rst), .key_half(key_half), .key_one(key_one),
    .inhibit(inhibit), .coin(coin), .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // observe n edges: first nonzero coin edge, its code, the code one edge later, totals
  task automatic watch(input int n, output int first, output int c1, output int c2, output int hits, output int rejs);
    first = 0; c1 = 0; c2 = 0; hits = 0; rejs = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (coin != 2'b00) begin
        hits++;
        if (first == 0) begin
          first = i;
          c1 = coin;
        end else if (i == first + 1) c2 = coin;
      end
      if (reject) rejs++;
    end
  endtask

  // reference: a key event happens once the level seen two edges late has differed from the
  // accepted level for DC consecutive edges; events then drain one per edge from a FIFO
  task automatic model_step();
    logic [1:0] raw;
    raw = {key_one, key_half};
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        h1[k] = 1; h2[k] = 1; stab[k] = 1; run[k] = 0; pev[k] = 0;
      end
      q.delete();
      exp_coin = 0;
      exp_rej = 0;
      return;
    end
    if (pev[0]) q.push_back(1);
    if (pev[1]) q.push_back(2);
    exp_coin = 0;
    exp_rej = 0;
    if (q.size() > 0) begin
      int c;
      c = q.pop_front();
      if (inhibit) begin
        exp_rej = 1;
        rej_val += c;
      end else exp_coin = c;
    end
    for (int k = 0; k < 2; k++) begin
      int lvl;
      lvl = h2[k];
      h2[k] = h1[k];
      h1[k] = int'(raw[k]);
      pev[k] = 0;
      if (lvl != stab[k]) begin
        run[k]++;
        if (run[k] == DC) begin
          stab[k] = lvl;
          run[k] = 0;
          if (lvl == 0) begin
            pev[k] = 1;
            press_sum += k + 1;
          end
        end
      end else run[k] = 0;
    end
  endtask

  initial begin
    int f, c1, c2, h, r, acc;
    int dur[2], idur;
    int em_dut, em_mdl, rj_dut, rj_mdl;
    em_dut = 0; em_mdl = 0; rj_dut = 0; rj_mdl = 0;
    rst = 1'b1; key_half = 1'b0; key_one = 1'b0; inhibit = 1'b1;
    tick(3);
    check("rst_coin", coin, 0);
    check("rst_reject", reject, 0);
    rst = 1'b0;
    tick(1);
    check("post_rst_coin", coin, 0);
    check("post_rst_reject", reject, 0);
    watch(14, f, c1, c2, h, r);
    check("held_rst_hits", h, 0);
    check("held_rst_rejs", r, 0);
    key_half = 1'b1; key_one = 1'b1; inhibit = 1'b0;
    tick(15);

    key_half = 1'b0;
    watch(20, f, c1, c2, h, r);
    check("half_edge", f, 7);
    check("half_code", c1, 1);
    check("half_hits", h, 1);
    check("half_rejs", r, 0);
    key_half = 1'b1;
    watch(20, f, c1, c2, h, r);
    check("half_release_hits", h, 0);

    acc = 0;
    for (int b = 0; b < 6; b++) begin
      key_one = (b % 2 == 1);
      watch(2, f, c1, c2, h, r);
      acc += h;
    end
    check("bounce_hits", acc, 0);
    key_one = 1'b0;
    watch(20, f, c1, c2, h, r);
    check("bounce_edge", f, 7);
    check("bounce_code", c1, 2);
    check("bounce_hits_after", h, 1);
    key_one = 1'b1;
    tick(20);

    key_half = 1'b0; key_one = 1'b0;
    watch(20, f, c1, c2, h, r);
    check("both_edge", f, 7);
    check("both_first", c1, 1);
    check("both_second", c2, 2);
    check("both_hits", h, 2);
    check("both_rejs", r, 0);
    key_half = 1'b1; key_one = 1'b1;
    tick(20);

    inhibit = 1'b1; key_one = 1'b0;
    watch(20, f, c1, c2, h, r);
    check("inh_hits", h, 0);
    check("inh_rejs", r, 1);
    key_one = 1'b1;
    tick(20);
    inhibit = 1'b0; key_one = 1'b0;
    watch(20, f, c1, c2, h, r);
    check("uninh_edge", f, 7);
    check("uninh_code", c1, 2);
    key_one = 1'b1;
    tick(20);

    key_half = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    watch(12, f, c1, c2, h, r);
    check("rst_mid_hits", h, 0);
    check("rst_mid_rejs", r, 0);
    key_half = 1'b1;
    watch(15, f, c1, c2, h, r);
    check("rst_release_hits", h, 0);
    key_half = 1'b0;
    watch(20, f, c1, c2, h, r);
    check("repress_edge", f, 7);
    check("repress_code", c1, 1);
    check("repress_hits", h, 1);
    key_half = 1'b1;
    tick(20);

    dur[0] = 0; dur[1] = 0; idur = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rnd_coin", coin, exp_coin);
        check("rnd_reject", reject, exp_rej);
        check("rnd_coin11", int'(coin == 2'b11), 0);
        em_dut += coin; em_mdl += exp_coin;
        rj_dut += int'(reject); rj_mdl += exp_rej;
      end
      rst = (i < 3);
      if (i < 10 || i >= 2460) begin
        key_half = 1'b1;
        key_one = 1'b1;
      end else begin
        if (dur[0] == 0) begin
          key_half = ~key_half;
          dur[0] = $urandom_range(1, 3 * DC);
          if ($urandom_range(0, 5) == 0) begin
            key_one = key_half;
            dur[1] = dur[0] + 1;
          end
        end else dur[0]--;
        if (dur[1] == 0) begin
          key_one = ~key_one;
          dur[1] = $urandom_range(1, 3 * DC);
        end else dur[1]--;
      end
      if (idur == 0) begin
        inhibit = ($urandom_range(0, 9) < 3);
        idur = $urandom_range(1, 15);
      end else idur--;
      @(posedge clk);
      model_step();
    end
    check("emit_total", em_dut, em_mdl);
    check("reject_total", rj_dut, rj_mdl);
    check("value_balance", em_dut + rej_val, press_sum);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/coin_encoder.md
COIN_ENCODER -- requirements
Module: coin_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYC, default 1_000_000, stable-level cycles needed to accept a key change (20 ms at 50 MHz).
REQ-002 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: key_half  input  1  raw asynchronous 0.5-yuan coin key, active-low (pressed = 0).
REQ-005 Port: key_one  input  1  raw asynchronous 1-yuan coin key, active-low.
REQ-006 Port: inhibit  input  1  high while the coin consumer must not receive coins.
REQ-007 Port: coin  output  2  registered coin code: 2'b00 none, 2'b01 0.5 yuan, 2'b10 1 yuan; 2'b11 never driven.
REQ-008 Port: reject  output  1  one-cycle pulse when an accepted press is discarded because of inhibit.

Function
REQ-009 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Debounce per key: the counter increments while the synchronized level differs from the stable state, and clears whenever the levels match.
REQ-011 The stable state SHALL toggle, and the counter SHALL clear, when the counter reaches DEBOUNCE_CYC-1 with the level still different.
REQ-012 A press event SHALL be a stable-state 1->0 transition; releases and bounces shorter than DEBOUNCE_CYC cycles produce no event.
REQ-013 Encoder states: IDLE (coin=00), EMIT (coin driven one cycle), PEND (one press held for the next cycle).
REQ-014 A single press event with inhibit low SHALL drive coin with its code for exactly one cycle, then return to 2'b00.
REQ-015 Latency: coin asserts DEBOUNCE_CYC+3 rising edges after the first edge sampling the key low, bounce-free.
REQ-016 Simultaneous half and one events in the same cycle SHALL emit 2'b01 first, then 2'b10 the next cycle (via PEND), without loss.
REQ-017 A new event arriving while PEND is occupied SHALL be queued behind it, one per cycle; at most one event per key is outstanding, which debounce timing guarantees.
REQ-018 A press event with inhibit high SHALL leave coin at 2'b00 and pulse reject for one cycle, one pulse per discarded event; it is not queued.
REQ-019 Inhibit is sampled in the cycle the code would be driven; a PEND entry found inhibited SHALL be discarded with a reject pulse.
REQ-020 Coin SHALL stay at 2'b00 in every cycle without a valid emission, so consecutive nonzero codes occur only for REQ-016/017.
REQ-021 A key held down indefinitely SHALL produce exactly one event, with no auto-repeat.

Reset
REQ-022 While rst is high: coin=2'b00, reject=0, FSM=IDLE, PEND cleared, debounce counters 0, synchronizers and stable states 1 (released).
REQ-023 Reset mid-debounce or mid-PEND SHALL discard the in-flight event; a key still held at reset release SHALL register only after release and a fresh press.
REQ-024 The first cycle after rst deasserts SHALL produce no coin or reject regardless of key levels.

Structure
REQ-025 Shared package vm_pkg SHALL hold the coin codes COIN_NONE/COIN_HALF/COIN_ONE and the encoder state encoding; the vending FSM SHALL use the same codes.
REQ-026 A sub-module key_debounce (synchronizer, counter, stable state, press pulse) SHALL be instantiated once per key; arbitration and the FSM stay in coin_encoder.
REQ-027 Expected size is 120-250 lines total, with no latches and all outputs registered.

Verification (DEBOUNCE_CYC=4)
REQ-028 Clean key_half press held 20 cycles -> coin=01 for one cycle at edge 7 after the press, then 00; no second pulse on release.
REQ-029 key_one bouncing low/high every 2 cycles for 12 cycles, then held low -> exactly one coin=10, 7 edges after the final stable low.
REQ-030 key_half and key_one pressed on the same edge -> coin=01 then coin=10 on consecutive cycles, reject stays 0.
REQ-031 inhibit=1 with a key_one press -> coin stays 00, reject pulses once; after inhibit=0, a new press -> coin=10.
REQ-032 rst asserted 2 cycles after a key_half press, key still held, released at cycle 15, pressed again -> no coin until the second press, then 01.
REQ-033 Scoreboard across random presses: sum of emitted values plus rejected values equals the sum of debounced press values, and coin never equals 11.
